// File: rtl/retire_stage_pkg.sv
// Shared definitions for the in-order retire stage.
//  - datapath widths (XLEN, ROB tag, register index, retire counter)
//  - retire FSM state encodings, exported on the debug state port
//  - rob_retire_packet_t: the ROB head entry as seen by the retire stage
//  - rf_write_eligible(): architectural write qualifier (x0 is never written)
package retire_stage_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 6;
  localparam int REG_W     = 5;
  localparam int CNT_W     = 32;

  localparam logic [1:0] RS_IDLE   = 2'd0;
  localparam logic [1:0] RS_STORE  = 2'd1;
  localparam logic [1:0] RS_FLUSH  = 2'd2;
  localparam logic [1:0] RS_HALTED = 2'd3;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic [ROB_TAG_W-1:0] tag;
    logic [REG_W-1:0]     dest;
    logic [XLEN-1:0]      value;
    logic                 reg_valid;
    logic                 is_store;
    logic [XLEN-1:0]      st_addr;
    logic [XLEN-1:0]      st_data;
    logic                 mispredict;
    logic [XLEN-1:0]      target;
    logic                 halt;
  } rob_retire_packet_t;

  function automatic logic rf_write_eligible(input logic reg_valid,
                                             input logic [REG_W-1:0] dest);
    return reg_valid && (dest != '0);
  endfunction

endpackage

// File: rtl/retire_stage.sv
// In-order commit stage sitting directly behind the reorder buffer.
// Looks at the ROB head every cycle and commits at most one instruction:
// regfile write + map-table clear, store release over a req/ack handshake,
// mispredict redirect with full flush, or halt.
//
// Ports
//  clock, reset            clock; asynchronous active-low reset
//  head_*                  ROB head entry fields
//  st_req_ack              memory accepted the outstanding store this cycle
//  retire_entry, rob_clear ROB pop / machine-wide squash at the next posedge
//  rf_wr_*                 architectural regfile write port
//  map_clear_en/_tag       map-table clear for the retiring tag
//  redirect_valid/_pc      fetch redirect on mispredict
//  st_req_valid/_addr/_data registered store request
//  halted                  sticky halt flag
//  retired_count           wrapping count of retired instructions
//  dbg_state_o             current retire FSM state
//
// Store handshake: st_req_valid/addr/data are registered. Once valid rises,
// addr and data stay stable until a cycle in which st_req_ack=1; that cycle
// completes the transfer and valid drops at the following edge. An ack while
// no request is outstanding has no effect.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic [ROB_TAG_W-1:0] head_tag,
  input  logic [REG_W-1:0]     head_dest,
  input  logic [XLEN-1:0]      head_value,
  input  logic                 head_reg_valid,
  input  logic                 head_is_store,
  input  logic [XLEN-1:0]      head_st_addr,
  input  logic [XLEN-1:0]      head_st_data,
  input  logic                 head_mispredict,
  input  logic [XLEN-1:0]      head_target,
  input  logic                 head_halt,
  input  logic                 st_req_ack,
  output logic                 retire_entry,
  output logic                 rob_clear,
  output logic                 rf_wr_en,
  output logic [REG_W-1:0]     rf_wr_idx,
  output logic [XLEN-1:0]      rf_wr_data,
  output logic                 map_clear_en,
  output logic [ROB_TAG_W-1:0] map_clear_tag,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 st_req_valid,
  output logic [XLEN-1:0]      st_req_addr,
  output logic [XLEN-1:0]      st_req_data,
  output logic                 halted,
  output logic [CNT_W-1:0]     retired_count,
  output logic [1:0]           dbg_state_o
);

  rob_retire_packet_t head;
  logic               commit;
  logic               wr_ok;

  logic [1:0]       state_q,     state_d;
  logic             st_valid_q,  st_valid_d;
  logic [XLEN-1:0]  st_addr_q,   st_addr_d;
  logic [XLEN-1:0]  st_data_q,   st_data_d;
  logic             halted_q,    halted_d;
  logic [CNT_W-1:0] count_q,     count_d;

  assign head = '{valid:      head_valid,
                  ready:      head_ready,
                  tag:        head_tag,
                  dest:       head_dest,
                  value:      head_value,
                  reg_valid:  head_reg_valid,
                  is_store:   head_is_store,
                  st_addr:    head_st_addr,
                  st_data:    head_st_data,
                  mispredict: head_mispredict,
                  target:     head_target,
                  halt:       head_halt};

  assign commit = head.valid && head.ready;
  assign wr_ok  = rf_write_eligible(head.reg_valid, head.dest);

  // Next state and combinational commit outputs. Everything stays zero
  // while reset is asserted so the ROB never sees a pop during reset.
  always_comb begin
    state_d        = state_q;
    st_valid_d     = st_valid_q;
    st_addr_d      = st_addr_q;
    st_data_d      = st_data_q;
    halted_d       = halted_q;
    retire_entry   = 1'b0;
    rob_clear      = 1'b0;
    rf_wr_en       = 1'b0;
    rf_wr_idx      = '0;
    rf_wr_data     = '0;
    map_clear_en   = 1'b0;
    map_clear_tag  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    if (reset) begin
      case (state_q)
        RS_IDLE: begin
          if (commit) begin
            if (head.halt) begin
              retire_entry = 1'b1;
              halted_d     = 1'b1;
              state_d      = RS_HALTED;
            end else if (head.is_store) begin
              // The store retires only once memory accepts it.
              st_valid_d = 1'b1;
              st_addr_d  = head.st_addr;
              st_data_d  = head.st_data;
              state_d    = RS_STORE;
            end else begin
              retire_entry = 1'b1;
              if (wr_ok) begin
                rf_wr_en      = 1'b1;
                rf_wr_idx     = head.dest;
                rf_wr_data    = head.value;
                map_clear_en  = 1'b1;
                map_clear_tag = head.tag;
              end
              if (head.mispredict) begin
                rob_clear      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = head.target;
                state_d        = RS_FLUSH;
              end
            end
          end
        end
        RS_STORE: begin
          if (st_req_ack) begin
            retire_entry = 1'b1;
            st_valid_d   = 1'b0;
            state_d      = RS_IDLE;
          end
        end
        RS_FLUSH: begin
          // Bubble while the squash propagates; the head is stale here.
          state_d = RS_IDLE;
        end
        default: begin
          // RS_HALTED absorbs until reset.
          state_d = RS_HALTED;
        end
      endcase
    end
  end

  assign count_d = retire_entry ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RS_IDLE;
      st_valid_q <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      st_valid_q <= st_valid_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
      halted_q   <= halted_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign st_req_valid  = st_valid_q;
  assign st_req_addr   = st_addr_q;
  assign st_req_data   = st_data_q;
  assign halted        = halted_q;
  assign retired_count = count_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_retire_stage.sv
module tb_retire_stage;
  import retire_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                 head_valid, head_ready, head_reg_valid, head_is_store;
  logic                 head_mispredict, head_halt, st_req_ack;
  logic [ROB_TAG_W-1:0] head_tag;
  logic [REG_W-1:0]     head_dest;
  logic [XLEN-1:0]      head_value, head_st_addr, head_st_data, head_target;
  logic                 retire_entry, rob_clear, rf_wr_en, map_clear_en;
  logic                 redirect_valid, st_req_valid, halted;
  logic [REG_W-1:0]     rf_wr_idx;
  logic [XLEN-1:0]      rf_wr_data, redirect_pc, st_req_addr, st_req_data;
  logic [ROB_TAG_W-1:0] map_clear_tag;
  logic [CNT_W-1:0]     retired_count;
  logic [1:0]           dbg_state;

  retire_stage dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
    .head_dest(head_dest), .head_value(head_value), .head_reg_valid(head_reg_valid),
    .head_is_store(head_is_store), .head_st_addr(head_st_addr),
    .head_st_data(head_st_data), .head_mispredict(head_mispredict),
    .head_target(head_target), .head_halt(head_halt), .st_req_ack(st_req_ack),
    .retire_entry(retire_entry), .rob_clear(rob_clear), .rf_wr_en(rf_wr_en),
    .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data), .map_clear_en(map_clear_en),
    .map_clear_tag(map_clear_tag), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .st_req_valid(st_req_valid),
    .st_req_addr(st_req_addr), .st_req_data(st_req_data), .halted(halted),
    .retired_count(retired_count), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  // record = {rf_wr_en, map_clear_en, rf_wr_idx, rf_wr_data, map_clear_tag}
  localparam int RW = 2 + REG_W + XLEN + ROB_TAG_W;
  logic [RW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_count;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_retire(input logic wr, input logic [REG_W-1:0] idx,
                               input logic [XLEN-1:0] data, input logic [ROB_TAG_W-1:0] tag);
    exp_q.push_back({wr, wr, idx, data, tag});
    exp_count = exp_count + 1'b1;
  endtask

  // Compare retire_entry against the expectation; on a retire, pop and
  // compare the commit record.
  task automatic check_retire(input string tag, input logic exp_ret);
    logic [RW-1:0] e;
    chk({tag, ".retire_entry"}, 64'(retire_entry), 64'(exp_ret));
    if (retire_entry) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".unexpected_retire"}, 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk({tag, ".rf_wr_en"}, 64'(rf_wr_en), 64'(e[RW-1]));
        chk({tag, ".map_clear_en"}, 64'(map_clear_en), 64'(e[RW-2]));
        if (e[RW-1]) begin
          chk({tag, ".rf_wr_idx"}, 64'(rf_wr_idx), 64'(e[XLEN+ROB_TAG_W +: REG_W]));
          chk({tag, ".rf_wr_data"}, 64'(rf_wr_data), 64'(e[ROB_TAG_W +: XLEN]));
          chk({tag, ".map_clear_tag"}, 64'(map_clear_tag), 64'(e[ROB_TAG_W-1:0]));
        end
      end
    end else begin
      chk({tag, ".rf_wr_en_idle"}, 64'(rf_wr_en), 64'(0));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_head();
    head_valid = 0; head_ready = 0; head_tag = '0; head_dest = '0; head_value = '0;
    head_reg_valid = 0; head_is_store = 0; head_st_addr = '0; head_st_data = '0;
    head_mispredict = 0; head_target = '0; head_halt = 0;
  endtask

  task automatic drive_alu(input logic rdy, input logic [ROB_TAG_W-1:0] tag,
                           input logic [REG_W-1:0] dest, input logic [XLEN-1:0] value,
                           input logic reg_valid);
    clear_head();
    head_valid = 1; head_ready = rdy; head_tag = tag; head_dest = dest;
    head_value = value; head_reg_valid = reg_valid;
  endtask

  task automatic drive_store(input logic [ROB_TAG_W-1:0] tag, input logic [XLEN-1:0] addr,
                             input logic [XLEN-1:0] data);
    clear_head();
    head_valid = 1; head_ready = 1; head_tag = tag; head_is_store = 1;
    head_st_addr = addr; head_st_data = data;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_count = '0;
    st_req_ack = 0;
    // A committable head during reset must not retire.
    drive_alu(1, 6'd9, 5'd4, 32'h1111_1111, 1);
    #1;
    chk("rst.retire_entry", 64'(retire_entry), 64'(0));
    chk("rst.rf_wr_en", 64'(rf_wr_en), 64'(0));
    tick(); tick();
    chk("rst.count", 64'(retired_count), 64'(0));
    chk("rst.st_req_valid", 64'(st_req_valid), 64'(0));
    chk("rst.halted", 64'(halted), 64'(0));
    chk("rst.state", 64'(dbg_state), 64'(RS_IDLE));
    clear_head();
    reset = 1;
    tick();

    // 1: single ALU op
    drive_alu(1, 6'd1, 5'd1, 32'hFFFF_FFFF, 1);
    expect_retire(1, 5'd1, 32'hFFFF_FFFF, 6'd1);
    #1; check_retire("alu", 1);
    tick();
    chk("alu.count", 64'(retired_count), 64'(exp_count));

    // 2: stall three cycles, then commit
    drive_alu(0, 6'd2, 5'd3, 32'h1234_5678, 1);
    for (int i = 0; i < 3; i++) begin
      #1; check_retire("stall", 0);
      tick();
    end
    chk("stall.count", 64'(retired_count), 64'(exp_count));
    head_ready = 1;
    expect_retire(1, 5'd3, 32'h1234_5678, 6'd2);
    #1; check_retire("stall_go", 1);
    tick();
    chk("stall_go.count", 64'(retired_count), 64'(exp_count));

    // 3: store with delayed ack
    drive_store(6'd3, 32'h100, 32'hDEAD_BEEF);
    #1; check_retire("st_issue", 0);
    tick();
    chk("st.req_valid", 64'(st_req_valid), 64'(1));
    chk("st.req_addr", 64'(st_req_addr), 64'(32'h100));
    chk("st.req_data", 64'(st_req_data), 64'(32'hDEAD_BEEF));
    // A different head while waiting must be ignored.
    drive_alu(1, 6'd20, 5'd6, 32'hABCD_0000 | $urandom_range(0, 255), 1);
    for (int i = 0; i < 3; i++) begin
      #1; check_retire("st_wait", 0);
      chk("st_wait.addr", 64'(st_req_addr), 64'(32'h100));
      chk("st_wait.data", 64'(st_req_data), 64'(32'hDEAD_BEEF));
      tick();
    end
    drive_store(6'd3, 32'h100, 32'hDEAD_BEEF);
    st_req_ack = 1;
    expect_retire(0, '0, '0, '0);
    #1; check_retire("st_ack", 1);
    tick();
    clear_head();
    chk("st_done.req_valid", 64'(st_req_valid), 64'(0));
    chk("st_done.count", 64'(retired_count), 64'(exp_count));
    // Ack while no request is outstanding
    #1; check_retire("stray_ack", 0);
    tick();
    st_req_ack = 0;
    chk("stray_ack.state", 64'(dbg_state), 64'(RS_IDLE));

    // 4: mispredict to x0, then flush bubble
    drive_alu(1, 6'd4, 5'd0, 32'h8, 1);
    head_mispredict = 1; head_target = 32'h40;
    expect_retire(0, '0, '0, '0);
    #1; check_retire("mis", 1);
    chk("mis.rob_clear", 64'(rob_clear), 64'(1));
    chk("mis.redirect_valid", 64'(redirect_valid), 64'(1));
    chk("mis.redirect_pc", 64'(redirect_pc), 64'(32'h40));
    tick();
    drive_alu(1, 6'd5, 5'd2, 32'h55, 1);
    #1; check_retire("flush", 0);
    chk("flush.rob_clear", 64'(rob_clear), 64'(0));
    chk("flush.redirect_valid", 64'(redirect_valid), 64'(0));
    tick();
    expect_retire(1, 5'd2, 32'h55, 6'd5);
    #1; check_retire("resume", 1);
    tick();
    // Mispredicting JAL-style op that also writes a link register
    drive_alu(1, 6'd6, 5'd7, 32'hAA, 1);
    head_mispredict = 1; head_target = 32'h80;
    expect_retire(1, 5'd7, 32'hAA, 6'd6);
    #1; check_retire("mis_link", 1);
    chk("mis_link.redirect_pc", 64'(redirect_pc), 64'(32'h80));
    tick();
    clear_head();
    #1; check_retire("flush2", 0);
    tick();
    chk("mis.count", 64'(retired_count), 64'(exp_count));

    // 5: x0 destination and non-writing op
    drive_alu(1, 6'd7, 5'd0, 32'h77, 1);
    expect_retire(0, '0, '0, '0);
    #1; check_retire("x0", 1);
    tick();
    drive_alu(1, 6'd8, 5'd5, 32'h99, 0);
    expect_retire(0, '0, '0, '0);
    #1; check_retire("noreg", 1);
    tick();
    chk("x0.count", 64'(retired_count), 64'(exp_count));

    // 6a: reset in the middle of a store
    drive_store(6'd10, 32'h200, 32'hCAFE_F00D);
    tick();
    chk("rst_st.req_valid_before", 64'(st_req_valid), 64'(1));
    clear_head();
    #2;
    reset = 0;
    #1;
    chk("rst_st.req_valid", 64'(st_req_valid), 64'(0));
    chk("rst_st.count", 64'(retired_count), 64'(0));
    exp_count = '0;
    tick();
    reset = 1;
    st_req_ack = 1;
    #1; check_retire("rst_st.no_replay", 0);
    tick();
    st_req_ack = 0;
    chk("rst_st.req_after", 64'(st_req_valid), 64'(0));

    // 6b: halt then nothing retires
    clear_head();
    head_valid = 1; head_ready = 1; head_halt = 1; head_tag = 6'd11;
    expect_retire(0, '0, '0, '0);
    #1; check_retire("halt", 1);
    tick();
    chk("halt.halted", 64'(halted), 64'(1));
    chk("halt.state", 64'(dbg_state), 64'(RS_HALTED));
    drive_alu(1, 6'd12, 5'd9, 32'h1234, 1);
    for (int i = 0; i < 2; i++) begin
      #1; check_retire("halted_head", 0);
      tick();
    end
    chk("halt.count", 64'(retired_count), 64'(exp_count));
    chk("halt.sticky", 64'(halted), 64'(1));
    chk("sb.empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
